// File: rtl/ctrl_axil_master.sv
// ctrl_axil_master: AXI4-Lite initiator for a control_s_axi register slave.
// Takes one register read or write command at a time from a sequencer or host FSM,
// runs the matching AXI4-Lite channel sequence, and returns the read data and the
// response code as a one-cycle completion pulse.
//
// Ports:
//   ap_clk, ap_rst_n              clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake (cmd_ready high only when idle)
//   cmd_write/addr/wdata/wstrb    command payload (1 = write, 0 = read)
//   rsp_valid/rsp_rdata/rsp_resp  completion pulse, read data (0 for writes), response
//   m_axi_aw*/w*/b*/ar*/r*        AXI4-Lite master channels
//
// Optional feature: define CTRL_AXIL_TIMEOUT_EN to enable a watchdog that abandons a
// transaction after TIMEOUT_CYCLES busy cycles and reports rsp_resp = 2'b11.
module ctrl_axil_master #(
   parameter int ADDR_WIDTH     = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   input  logic [1:0]              m_axi_bresp,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
   // Clears the byte-lane bits so every access is word aligned.
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {{(ADDR_WIDTH-ADDR_LSB){1'b1}}, {ADDR_LSB{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_REQ  = 3'd1,
      S_WR_RESP = 3'd2,
      S_RD_REQ  = 3'd3,
      S_RD_DATA = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t                  state_q, state_d;
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [1:0]              rsp_resp_q, rsp_resp_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    bready_q, bready_d;
   logic                    arvalid_q, arvalid_d;
   logic                    rready_q, rready_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
   logic                    aw_fin_s, w_fin_s;

`ifdef CTRL_AXIL_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_s;
`endif

   // Next-state and next-output computation for the whole transaction FSM.
   always_comb begin
      state_d     = state_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      // A channel counts as finished if its valid already dropped or it handshakes now.
      aw_fin_s    = !awvalid_q || m_axi_awready;
      w_fin_s     = !wvalid_q || m_axi_wready;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               addr_d  = cmd_addr & ADDR_MASK;
               wdata_d = cmd_wdata;
               wstrb_d = cmd_wstrb;
               if (cmd_write) begin
                  state_d   = S_WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = S_RD_REQ;
                  arvalid_d = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WR_REQ: begin
            // AW and W retire independently; each valid drops after its own handshake.
            awvalid_d = awvalid_q && !m_axi_awready;
            wvalid_d  = wvalid_q && !m_axi_wready;
            if (aw_fin_s && w_fin_s) begin
               state_d  = S_WR_RESP;
               bready_d = 1'b1;
            end else begin
               state_d = S_WR_REQ;
            end
         end
         S_WR_RESP: begin
            if (m_axi_bvalid) begin
               state_d     = S_DONE;
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_resp_d  = m_axi_bresp;
               rsp_rdata_d = {DATA_WIDTH{1'b0}};
            end else begin
               state_d = S_WR_RESP;
            end
         end
         S_RD_REQ: begin
            if (m_axi_arready) begin
               state_d   = S_RD_DATA;
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end else begin
               state_d = S_RD_REQ;
            end
         end
         S_RD_DATA: begin
            if (m_axi_rvalid) begin
               state_d     = S_DONE;
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_resp_d  = m_axi_rresp;
               rsp_rdata_d = m_axi_rdata;
            end else begin
               state_d = S_RD_DATA;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d   = S_IDLE;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
         end
      endcase

`ifdef CTRL_AXIL_TIMEOUT_EN
      busy_s = (state_q == S_WR_REQ) || (state_q == S_WR_RESP) ||
               (state_q == S_RD_REQ) || (state_q == S_RD_DATA);
      // A completion in the last allowed cycle wins over the watchdog.
      if (busy_s && (state_d != S_DONE)) begin
         if (cnt_q == CNT_LAST) begin
            state_d     = S_DONE;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_resp_d  = 2'b11;
            rsp_rdata_d = {DATA_WIDTH{1'b0}};
            cnt_d       = {CNT_W{1'b0}};
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = {CNT_W{1'b0}};
      end
`endif

      // cmd_ready is a register that is high exactly while the FSM sits in IDLE.
      cmd_ready_d = (state_d == S_IDLE);
   end

   // State and registered outputs; reset returns to IDLE with every output low.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q     <= S_IDLE;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= {DATA_WIDTH{1'b0}};
         rsp_resp_q  <= 2'b00;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         addr_q      <= {ADDR_WIDTH{1'b0}};
         wdata_q     <= {DATA_WIDTH{1'b0}};
         wstrb_q     <= {STRB_WIDTH{1'b0}};
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
      end
   end

`ifdef CTRL_AXIL_TIMEOUT_EN
   // Watchdog counter of busy cycles for the current transaction.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign cmd_ready     = cmd_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_bready  = bready_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_rready  = rready_q;

endmodule
